// File: rtl/seq_pattern_gen_if.sv
// Handshake and status bundle for the serial pattern transmitter.
// The controller side (bench or sequencer) uses master; the generator uses slave.
interface seq_pattern_gen_if #(
    parameter int GAP_W = 4
);
    logic             start;
    logic [7:0]       repeat_count;
    logic [GAP_W-1:0] gap_len;
    logic             dout;
    logic             dout_valid;
    logic             busy;
    logic             done;
    logic [7:0]       sent_count;

    modport master (
        output start, repeat_count, gap_len,
        input  dout, dout_valid, busy, done, sent_count
    );

    modport slave (
        input  start, repeat_count, gap_len,
        output dout, dout_valid, busy, done, sent_count
    );
endinterface

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: emits PATTERN MSB first, repeated a latched
// number of times with a latched run of zero bits between repeats.
//
//   state | meaning
//   IDLE  | waiting for start; outputs quiet, sent_count holds last value
//   SHIFT | presenting pattern bit PATTERN[idx]
//   GAP   | presenting a zero bit between two pattern instances
//   DONE  | one-cycle done pulse, then back to IDLE
//
// Every output is a register loaded with the value belonging to the next
// state, so outputs change on the same edge as the state.
module seq_pattern_gen #(
    parameter int             PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int             GAP_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    seq_pattern_gen_if.slave  bus
);
    localparam int IDX_W = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [GAP_W-1:0] gap_lat, gap_lat_nxt;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;
    logic [7:0]       reps_lat, reps_lat_nxt;
    logic [7:0]       sent_q, sent_nxt;
    logic             dout_q, dout_nxt;
    logic             valid_q, valid_nxt;
    logic             busy_q, busy_nxt;
    logic             done_q, done_nxt;
    logic [IDX_W-1:0] idx_m1;
    logic             last_inst;

    assign idx_m1    = idx - 1'b1;
    assign last_inst = ((sent_q + 8'd1) == reps_lat);

    // State and output registers; reset clears everything, abandoning any burst.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            gap_lat  <= '0;
            gap_cnt  <= '0;
            reps_lat <= '0;
            sent_q   <= '0;
            dout_q   <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            gap_lat  <= gap_lat_nxt;
            gap_cnt  <= gap_cnt_nxt;
            reps_lat <= reps_lat_nxt;
            sent_q   <= sent_nxt;
            dout_q   <= dout_nxt;
            valid_q  <= valid_nxt;
            busy_q   <= busy_nxt;
            done_q   <= done_nxt;
        end
    end

    // Next state plus the output values that accompany it.
    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        gap_lat_nxt  = gap_lat;
        gap_cnt_nxt  = gap_cnt;
        reps_lat_nxt = reps_lat;
        sent_nxt     = sent_q;
        dout_nxt     = 1'b0;
        valid_nxt    = 1'b0;
        busy_nxt     = 1'b0;
        done_nxt     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    sent_nxt = '0;
                    if (bus.repeat_count != 8'd0) begin
                        reps_lat_nxt = bus.repeat_count;
                        gap_lat_nxt  = bus.gap_len;
                        idx_nxt      = IDX_MSB;
                        state_nxt    = SHIFT;
                        dout_nxt     = PATTERN[PAT_W-1];
                        valid_nxt    = 1'b1;
                        busy_nxt     = 1'b1;
                    end else begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (idx == '0) begin
                    sent_nxt = sent_q + 8'd1;
                    if (last_inst) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end else if (gap_lat == '0) begin
                        idx_nxt   = IDX_MSB;
                        dout_nxt  = PATTERN[PAT_W-1];
                        valid_nxt = 1'b1;
                        busy_nxt  = 1'b1;
                    end else begin
                        state_nxt   = GAP;
                        gap_cnt_nxt = gap_lat;
                        valid_nxt   = 1'b1;
                        busy_nxt    = 1'b1;
                    end
                end else begin
                    idx_nxt   = idx_m1;
                    dout_nxt  = PATTERN[idx_m1];
                    valid_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                end
            end
            GAP: begin
                // gap_cnt counts the gap cycles still to present, this one included
                if (gap_cnt == GAP_W'(1)) begin
                    state_nxt = SHIFT;
                    idx_nxt   = IDX_MSB;
                    dout_nxt  = PATTERN[PAT_W-1];
                end else begin
                    gap_cnt_nxt = gap_cnt - 1'b1;
                end
                valid_nxt = 1'b1;
                busy_nxt  = 1'b1;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.sent_count = sent_q;
endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen: expected bits are queued when a burst
// is requested and popped as valid bits appear on dout.
module tb_seq_pattern_gen;
    localparam int         PAT_W   = 4;
    localparam logic [3:0] PATTERN = 4'b1011;
    localparam int         GAP_W   = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;

    seq_pattern_gen_if #(.GAP_W(GAP_W)) bus ();

    seq_pattern_gen #(.PAT_W(PAT_W), .PATTERN(PATTERN), .GAP_W(GAP_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic       exp_q[$];
    int         cyc;
    int         done_cyc;
    int         valid_cnt;
    int         det_cnt;
    logic [3:0] det_sh;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; sample 1 time unit after the rising edge.
    task automatic step();
        logic e;
        @(posedge clk);
        #1;
        cyc++;
        check("busy_vs_valid", 32'(bus.busy), 32'(bus.dout_valid));
        if (bus.dout_valid === 1'b1) begin
            valid_cnt++;
            det_sh = {det_sh[2:0], bus.dout};
            if (det_sh === 4'b1011) det_cnt++;
            check("bit_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("dout_bit", 32'(bus.dout), 32'(e));
            end
        end
        if (bus.done === 1'b1 && done_cyc < 0) done_cyc = cyc;
    endtask

    task automatic push_burst(input int r, input int g);
        logic [3:0] pat;
        pat = PATTERN;
        for (int i = 0; i < r; i++) begin
            for (int b = PAT_W - 1; b >= 0; b--) exp_q.push_back(pat[b]);
            if (i < r - 1)
                for (int k = 0; k < g; k++) exp_q.push_back(1'b0);
        end
    endtask

    // Full burst with an optional stray start (repeat_count poke_r) during cycle poke_cyc.
    task automatic run_burst(input string tag, input int r, input int g,
                             input int poke_cyc, input int poke_r);
        int len;
        len = (r == 0) ? 0 : r * PAT_W + (r - 1) * g;
        exp_q.delete();
        push_burst(r, g);
        det_sh = 4'b0000;
        det_cnt = 0;
        valid_cnt = 0;
        done_cyc = -1;
        cyc = 0;
        bus.start = 1'b1;
        bus.repeat_count = 8'(r);
        bus.gap_len = GAP_W'(g);
        step();
        bus.start = 1'b0;
        for (int k = 0; k < 300 && done_cyc < 0; k++) begin
            if (cyc == poke_cyc) begin
                bus.start = 1'b1;
                bus.repeat_count = 8'(poke_r);
            end
            step();
            bus.start = 1'b0;
        end
        check({tag, "_done_cycle"}, 32'(done_cyc), 32'(len + 1));
        check({tag, "_valid_cycles"}, 32'(valid_cnt), 32'(len));
        check({tag, "_bits_left"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_sent_count"}, 32'(bus.sent_count), 32'(r));
        step();
        check({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
        check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_sent_hold"}, 32'(bus.sent_count), 32'(r));
    endtask

    initial begin
        bus.start = 1'b0;
        bus.repeat_count = 8'd0;
        bus.gap_len = '0;
        cyc = 0;
        done_cyc = -1;
        valid_cnt = 0;
        det_cnt = 0;
        det_sh = 4'b0000;

        reset = 1'b1;
        step();
        step();
        check("rst_dout", 32'(bus.dout), 32'd0);
        check("rst_valid", 32'(bus.dout_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_sent", 32'(bus.sent_count), 32'd0);
        reset = 1'b0;
        step();

        run_burst("single", 1, 0, 0, 0);

        run_burst("b2b", 2, 0, 0, 0);
        check("b2b_detections", 32'(det_cnt), 32'd2);

        run_burst("gapped", 3, 2, 0, 0);

        run_burst("zero", 0, 0, 0, 0);

        run_burst("busy_start", 2, 0, 3, 5);
        run_burst("after_done", 5, 0, 0, 0);

        exp_q.delete();
        push_burst(3, 1);
        det_sh = 4'b0000;
        valid_cnt = 0;
        done_cyc = -1;
        cyc = 0;
        bus.start = 1'b1;
        bus.repeat_count = 8'd3;
        bus.gap_len = GAP_W'(1);
        step();
        bus.start = 1'b0;
        while (cyc < 6) step();
        check("pre_reset_sent", 32'(bus.sent_count), 32'd1);
        check("pre_reset_valid", 32'(bus.dout_valid), 32'd1);
        reset = 1'b1;
        step();
        check("mid_rst_valid", 32'(bus.dout_valid), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        check("mid_rst_sent", 32'(bus.sent_count), 32'd0);
        exp_q.delete();
        reset = 1'b0;
        run_burst("post_reset", 3, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_pattern_gen.md
# seq_pattern_gen

Serial pattern transmitter that drives a single-bit stream carrying a fixed PAT_W-bit pattern (default 1011), MSB first, repeated a programmable number of times with a programmable run of zero bits between repeats. It is the stimulus end of the sequence-detection path: its `dout` feeds the `din` of a sequence detector. It also reports how many complete patterns it has emitted, so the downstream detection count can be checked against it.

## Interface
- `PAT_W`, default 4: pattern length in bits (≥2).
- `PATTERN`, default 4'b1011: pattern, transmitted MSB (bit PAT_W-1) first.
- `GAP_W`, default 4: width of the `gap_len` field.
- `clk`  input  1  rising-edge clock; the only clock.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  request a burst; sampled only in IDLE.
- `repeat_count`  input  8  number of pattern instances in the burst; latched on the accepted `start`.
- `gap_len`  input  GAP_W  zero bits inserted between consecutive instances; latched on the accepted `start`.
- `dout`  output  1  serial data bit (registered).
- `dout_valid`  output  1  high on every bit cycle of a burst, including gap bits (registered).
- `busy`  output  1  high from the first bit cycle through the last bit cycle of a burst.
- `done`  output  1  one-cycle pulse when a burst ends.
- `sent_count`  output  8  completed pattern instances in the current or last burst.

## Operation
- States: IDLE, SHIFT, GAP, DONE. All outputs are registered and update on the same edge as the state.
- Reset, applied on any edge, including mid-burst: state=IDLE, `dout`=0, `dout_valid`=0, `busy`=0, `done`=0, `sent_count`=0, and internal counters cleared. Takes effect on the next edge, with no partial pattern completion.
- IDLE: `dout`=0, `dout_valid`=0, `busy`=0.
  - On `start`=1 with `repeat_count`≠0: latch `repeat_count` and `gap_len`, clear `sent_count`, set bit index to PAT_W-1, go to SHIFT. Drive `dout`=PATTERN[PAT_W-1], `dout_valid`=1, `busy`=1.
  - On `start`=1 with `repeat_count`=0: clear `sent_count` and go to DONE. No bits are emitted and `busy` stays 0.
- SHIFT: each cycle presents PATTERN[idx], then decrements idx. When idx=0 is presented:
  - `sent_count` increments at the end of that cycle.
  - If instances remain and latched gap=0, reload idx=PAT_W-1 and stay in SHIFT. This gives back-to-back patterns with no idle bit.
  - If instances remain and gap>0, go to GAP with the gap counter set to the latched gap.
  - If this was the last instance, go to DONE.
- GAP: `dout`=0, `dout_valid`=1, `busy`=1 for exactly the latched gap cycles, then SHIFT with idx=PAT_W-1.
- DONE: `done`=1, `busy`=0, `dout_valid`=0, `dout`=0 for one cycle, then IDLE.
- `start` in SHIFT, GAP or DONE is ignored, not queued. Changes to `repeat_count` or `gap_len` during a burst have no effect.
- `sent_count` holds its final value in IDLE until the next accepted `start` or a reset. It never wraps, because it is bounded by `repeat_count` ≤ 255.

## Timing
- Latency: `start` sampled at edge E0 gives the first pattern bit valid in the cycle following E0.
- Burst length in `dout_valid` cycles = R·PAT_W + (R−1)·G, where R is the latched repeat count and G the latched gap.
- `done` is high in the cycle immediately after the last valid bit. `busy` falls at that same edge.
- With R=0, `done` is high in the cycle following E0.
- Earliest next accepted `start` is the first IDLE cycle after `done`. The minimum start-to-start spacing is burst length + 2 cycles.
- `dout` is glitch-free, registered, and changes only on rising edges of `clk`.

## Test plan
- Single pattern, defaults: `start`=1 for one cycle with `repeat_count`=1, `gap_len`=0.
  - Required: `dout`=1,0,1,1 with `dout_valid`=1 for 4 cycles.
  - Required: `done` pulses in the 5th cycle; `sent_count`=1.
- Back-to-back overlap: `repeat_count`=2, `gap_len`=0.
  - Required: `dout`=10111011 over 8 valid cycles with `busy`=1 throughout; `sent_count`=2.
  - Required: a connected overlapping 1011 detector asserts `detected` twice.
- Gapped burst: `repeat_count`=3, `gap_len`=2.
  - Required: `dout`=1011 00 1011 00 1011, 16 valid cycles.
  - Required: `done` in the 17th cycle; `sent_count`=3.
- Zero repeats: `repeat_count`=0, `start` pulse.
  - Required: `done`=1 in the next cycle; `dout_valid` and `busy` never assert; `sent_count`=0.
- Start while busy: a second `start` with `repeat_count`=5 during cycle 3 of a `repeat_count`=2 burst.
  - Required: the burst stays 8 bits long and `sent_count`=2.
  - Required: `repeat_count` is taken from a new `start` only after `done`.
- Reset mid-burst: assert `reset` in cycle 6 of a `repeat_count`=3, `gap_len`=1 burst.
  - Required: next cycle `dout_valid`=0, `busy`=0, `done`=0, `sent_count`=0.
  - Required: a fresh `start` then produces a full, correct burst.
